nabp_processing_ring_control: RTL and testbench

- N-slot generalisation of the two-way processing swap control.
- Sequences a ring of NUM_SLOTS processing swappables. Exactly one slot fills at a time while up to NUM_SLOTS-1 earlier slots are still shifting.
- Issues line iterations per angle and requests angles from the filtered RAM swap control.
- Generates PE kick/reset and the angle-setup strobe used to latch LUT results.

---
 rtl/nabp_processing_ring_control.sv | 171 +++++++++++++++++
 tb/tb_nabp_processing_ring_control.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_processing_ring_control.sv
// nabp_processing_ring_control
// Sequences a ring of NUM_SLOTS processing swappables. One slot fills while the
// earlier slots finish shifting. Line iterations are issued per angle, angles are
// requested from the filtered RAM swap control, and the PE kick/reset and
// angle-setup strobes are generated.
// Optional macro NABP_RING_STALL_STATS_EN: enables the saturating stall_count
// counter; when undefined stall_count is tied to zero.
module nabp_processing_ring_control #(
    parameter int unsigned NUM_SLOTS      = 2,
    parameter int unsigned PARTITION_SIZE = 16,
    parameter int unsigned PTR_W          = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1,
    parameter int unsigned ITR_W          = (PARTITION_SIZE > 2) ? $clog2(PARTITION_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fr_has_next_angle,
    input  logic                 fr_next_angle_ack,
    output logic                 fr_next_angle,
    input  logic [NUM_SLOTS-1:0] sl_fill_done,
    input  logic [NUM_SLOTS-1:0] sl_idle,
    output logic [NUM_SLOTS-1:0] sl_start,
    output logic [NUM_SLOTS-1:0] sl_swap_ack,
    output logic [PTR_W-1:0]     fill_ptr,
    output logic [ITR_W-1:0]     line_itr,
    output logic                 angle_setup,
    output logic                 pe_reset,
    output logic                 pe_kick,
    output logic                 busy,
    output logic [31:0]          stall_count
);

    typedef enum logic [2:0] {
        StReady, StSetup1, StSetup2, StRun, StReq, StAngle1, StAngle2, StDrain
    } state_t;

    localparam logic [PTR_W-1:0]     LastPtr  = PTR_W'(NUM_SLOTS - 1);
    localparam logic [ITR_W-1:0]     LastItr  = ITR_W'(PARTITION_SIZE - 1);
    localparam logic [NUM_SLOTS-1:0] OneHot0  = NUM_SLOTS'(1);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [ITR_W-1:0] itr_q, itr_d;

    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] start_idx;
    logic             can_swap;
    logic             do_start, start_nxt, do_swap, req, setup, per;

    // Explicit wrap so non-power-of-2 rings never index a missing slot
    assign next_ptr = (ptr_q == LastPtr) ? '0 : ptr_q + PTR_W'(1);
    assign can_swap = sl_fill_done[ptr_q] & sl_idle[next_ptr];

    // Next-state decode and Mealy pulse requests
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        itr_d     = itr_q;
        do_start  = 1'b0;
        start_nxt = 1'b0;
        do_swap   = 1'b0;
        req       = 1'b0;
        setup     = 1'b0;
        per       = 1'b0;
        case (state_q)
            StReady: begin
                req = fr_has_next_angle;
                if (fr_has_next_angle && fr_next_angle_ack) state_d = StSetup1;
            end
            // One cycle of LUT latency before the angle values are usable
            StSetup1: state_d = StSetup2;
            StSetup2: begin
                setup = 1'b1;
                itr_d = '0;
                if (sl_idle[ptr_q]) begin
                    do_start = 1'b1;
                    per      = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (can_swap) begin
                    if (itr_q != LastItr) begin
                        do_swap   = 1'b1;
                        do_start  = 1'b1;
                        start_nxt = 1'b1;
                        ptr_d     = next_ptr;
                        itr_d     = itr_q + ITR_W'(1);
                    end else if (fr_has_next_angle) begin
                        state_d = StReq;
                    end else begin
                        do_swap = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            // Slots hold fill_done until acked, so can_swap stays true through here
            StReq: begin
                req = 1'b1;
                if (!fr_has_next_angle) begin
                    do_swap = 1'b1;
                    state_d = StDrain;
                end else if (fr_next_angle_ack) begin
                    state_d = StAngle1;
                end
            end
            StAngle1: state_d = StAngle2;
            StAngle2: begin
                setup     = 1'b1;
                do_swap   = 1'b1;
                do_start  = 1'b1;
                start_nxt = 1'b1;
                ptr_d     = next_ptr;
                itr_d     = '0;
                state_d   = StRun;
            end
            StDrain: begin
                if (&sl_idle) state_d = StReady;
            end
            default: state_d = StReady;
        endcase
    end

    // State, fill pointer and line counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReady;
            ptr_q   <= '0;
            itr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            itr_q   <= itr_d;
        end
    end

    // Pulses are suppressed while reset is held
    assign start_idx     = start_nxt ? next_ptr : ptr_q;
    assign sl_start      = (do_start && !reset) ? (OneHot0 << start_idx) : '0;
    assign sl_swap_ack   = (do_swap && !reset) ? (OneHot0 << ptr_q) : '0;
    assign fr_next_angle = req && !reset;
    assign angle_setup   = setup && !reset;
    assign pe_reset      = per && !reset;
    assign pe_kick       = |sl_swap_ack;
    assign busy          = (state_q != StReady);
    assign fill_ptr      = ptr_q;
    assign line_itr      = itr_q;

`ifdef NABP_RING_STALL_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_cyc;

    assign stall_cyc = (state_q == StRun) && sl_fill_done[ptr_q] && !sl_idle[next_ptr];

    // Saturating count of cycles the filled slot waits on a busy successor
    always_comb begin
        stall_d = stall_q;
        if (stall_cyc && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_nabp_processing_ring_control.sv
// Bench for nabp_processing_ring_control: a table of per-cycle vectors against a
// 3-slot ring, plus sequences against a 2-slot ring driven by slot and RAM models.
module tb_nabp_processing_ring_control;

`ifdef NABP_RING_STALL_STATS_EN
    localparam int StallExp = 10;
`else
    localparam int StallExp = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- 3-slot DUT, driven directly from the vector table
    logic       r3, has3, ack3, nr3, as3, per3, kick3, busy3;
    logic [2:0] fd3, id3, st3, sw3;
    logic [1:0] ptr3, line3;
    logic [31:0] stall3;

    nabp_processing_ring_control #(.NUM_SLOTS(3), .PARTITION_SIZE(4)) u3 (
        .clk(clk), .reset(r3), .fr_has_next_angle(has3), .fr_next_angle_ack(ack3),
        .fr_next_angle(nr3), .sl_fill_done(fd3), .sl_idle(id3), .sl_start(st3),
        .sl_swap_ack(sw3), .fill_ptr(ptr3), .line_itr(line3), .angle_setup(as3),
        .pe_reset(per3), .pe_kick(kick3), .busy(busy3), .stall_count(stall3)
    );

    // ---------------- 2-slot DUT, driven by behavioural slot and RAM models
    logic       rst2, has2, ack2, nr2, as2, per2, kick2, busy2;
    logic [1:0] fd2, id2, st2, sw2, line2;
    logic [0:0] ptr2;
    logic [31:0] stall2;
    logic [1:0] force_busy;
    int fill_lat, shift_lat, ack_delay, angles_total;

    nabp_processing_ring_control #(.NUM_SLOTS(2), .PARTITION_SIZE(4)) u2 (
        .clk(clk), .reset(rst2), .fr_has_next_angle(has2), .fr_next_angle_ack(ack2),
        .fr_next_angle(nr2), .sl_fill_done(fd2), .sl_idle(id2), .sl_start(st2),
        .sl_swap_ack(sw2), .fill_ptr(ptr2), .line_itr(line2), .angle_setup(as2),
        .pe_reset(per2), .pe_kick(kick2), .busy(busy2), .stall_count(stall2)
    );

    // Slot model: fill for fill_lat cycles after start, hold done until acked, then shift
    logic [1:0] filling, shifting;
    int fcnt [2];
    int scnt [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst2) begin
                filling[i]  <= 1'b0;
                shifting[i] <= 1'b0;
                fcnt[i]     <= 0;
                scnt[i]     <= 0;
            end else begin
                if (st2[i]) begin
                    filling[i] <= 1'b1;
                    fcnt[i]    <= fill_lat;
                end else if (filling[i] && fcnt[i] > 0) begin
                    fcnt[i] <= fcnt[i] - 1;
                end
                if (sw2[i]) begin
                    filling[i]  <= 1'b0;
                    shifting[i] <= 1'b1;
                    scnt[i]     <= shift_lat;
                end else if (shifting[i]) begin
                    if (scnt[i] > 1) scnt[i] <= scnt[i] - 1;
                    else begin
                        shifting[i] <= 1'b0;
                        scnt[i]     <= 0;
                    end
                end
            end
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fd2[i] = filling[i] && (fcnt[i] == 0);
            id2[i] = !filling[i] && !shifting[i] && !force_busy[i];
        end
    end

    // RAM model: serve angles_total angles, acking each request after ack_delay cycles
    int acks_given, wcnt;
    assign has2 = (acks_given < angles_total);
    always @(posedge clk) begin
        if (rst2) begin
            ack2       <= 1'b0;
            acks_given <= 0;
            wcnt       <= 0;
        end else begin
            ack2 <= 1'b0;
            if (ack2) acks_given <= acks_given + 1;
            else if (nr2) begin
                if (wcnt >= ack_delay) begin
                    ack2 <= 1'b1;
                    wcnt <= 0;
                end else wcnt <= wcnt + 1;
            end
        end
    end

    // Event monitor for the 2-slot DUT, cleared by reset
    int n_start, n_swap, n_as, n_per, n_req_rise, n_multi, n_swap_in_req;
    logic [1:0] max_itr, itr_after_as;
    logic prev_nr, prev_as;
    logic start_log [16];
    always @(negedge clk) begin
        if (rst2) begin
            n_start <= 0; n_swap <= 0; n_as <= 0; n_per <= 0; n_req_rise <= 0;
            n_multi <= 0; n_swap_in_req <= 0; max_itr <= '0; itr_after_as <= '0;
            prev_nr <= 1'b0; prev_as <= 1'b0;
        end else begin
            prev_nr <= nr2;
            prev_as <= as2;
            if (|st2) begin
                if (n_start < 16) start_log[n_start] <= st2[1];
                n_start <= n_start + 1;
            end
            if (|sw2) n_swap <= n_swap + 1;
            if (as2) n_as <= n_as + 1;
            if (per2) n_per <= n_per + 1;
            if (nr2 && !prev_nr) n_req_rise <= n_req_rise + 1;
            if ($countones(st2) > 1 || $countones(sw2) > 1) n_multi <= n_multi + 1;
            if (nr2 && busy2 && |sw2) n_swap_in_req <= n_swap_in_req + 1;
            if (line2 > max_itr) max_itr <= line2;
            if (prev_as) itr_after_as <= line2;
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic reset2();
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (!busy2 && k < 100) begin @(negedge clk); k++; end
        while (busy2 && k < 3000) begin @(negedge clk); k++; end
        check({nm, "_done"}, {63'd0, busy2}, 64'd0);
    endtask

    function automatic logic [3:0] seq4();
        return {start_log[0], start_log[1], start_log[2], start_log[3]};
    endfunction

    // in = {reset, has, ack, fill_done[2:0], idle[2:0]}
    // ex = {fr_next_angle, start[2:0], swap[2:0], fill_ptr[1:0], line_itr[1:0],
    //       angle_setup, pe_reset, busy}
    typedef struct packed {
        logic [8:0]  in;
        logic [13:0] ex;
    } vec_t;
    vec_t vq[$];

    task automatic addv(input logic [8:0] in, input logic [13:0] ex);
        vec_t v;
        v.in = in;
        v.ex = ex;
        vq.push_back(v);
    endtask

    initial begin
        int k;
        logic [14:0] got3, exp3;

        // Vector table for the 3-slot ring (PARTITION_SIZE=4)
        addv(9'b0_0_0_000_111, 14'b0_000_000_00_00_0_0_0); // READY, no angle
        addv(9'b0_1_0_000_111, 14'b1_000_000_00_00_0_0_0); // request follows has
        addv(9'b0_1_1_000_111, 14'b1_000_000_00_00_0_0_0); // ack
        addv(9'b0_0_0_000_111, 14'b0_000_000_00_00_0_0_1); // SETUP1
        addv(9'b0_0_0_000_110, 14'b0_000_000_00_00_1_0_1); // SETUP2, slot0 busy
        addv(9'b0_0_0_000_111, 14'b0_001_000_00_00_1_1_1); // SETUP2 start0
        addv(9'b0_0_0_001_100, 14'b0_000_000_00_00_0_0_1); // next busy: hold
        addv(9'b0_0_0_001_110, 14'b0_010_001_00_00_0_0_1); // swap0 start1
        addv(9'b0_0_0_010_100, 14'b0_100_010_01_01_0_0_1); // swap1 start2
        addv(9'b0_0_0_100_000, 14'b0_000_000_10_10_0_0_1); // all busy
        addv(9'b0_0_0_100_001, 14'b0_001_100_10_10_0_0_1); // wrap 2->0
        addv(9'b0_0_0_001_010, 14'b0_000_001_00_11_0_0_1); // last line, no angle
        addv(9'b0_0_0_000_011, 14'b0_000_000_00_11_0_0_1); // DRAIN waits
        addv(9'b0_0_0_000_111, 14'b0_000_000_00_11_0_0_1); // DRAIN done
        addv(9'b0_0_0_000_111, 14'b0_000_000_00_11_0_0_0); // READY, ptr/itr held
        addv(9'b0_1_1_000_111, 14'b1_000_000_00_11_0_0_0); // second run
        addv(9'b0_0_0_000_111, 14'b0_000_000_00_11_0_0_1); // SETUP1
        addv(9'b0_0_0_000_111, 14'b0_001_000_00_11_1_1_1); // SETUP2 start0
        addv(9'b0_0_0_001_111, 14'b0_010_001_00_00_0_0_1);
        addv(9'b0_0_0_010_111, 14'b0_100_010_01_01_0_0_1);
        addv(9'b0_0_0_100_111, 14'b0_001_100_10_10_0_0_1);
        addv(9'b0_1_0_001_111, 14'b0_000_000_00_11_0_0_1); // last line, -> REQ
        addv(9'b0_1_0_001_111, 14'b1_000_000_00_11_0_0_1); // REQ waiting
        addv(9'b0_1_1_001_111, 14'b1_000_000_00_11_0_0_1); // REQ ack
        addv(9'b0_0_0_001_111, 14'b0_000_000_00_11_0_0_1); // ANGLE1
        addv(9'b0_0_0_001_111, 14'b0_010_001_00_11_1_0_1); // ANGLE2
        addv(9'b0_0_0_000_111, 14'b0_000_000_01_00_0_0_1); // RUN, itr cleared
        addv(9'b0_0_0_010_111, 14'b0_100_010_01_00_0_0_1);
        addv(9'b0_0_0_100_111, 14'b0_001_100_10_01_0_0_1);
        addv(9'b0_0_0_001_111, 14'b0_010_001_00_10_0_0_1);
        addv(9'b0_1_0_010_111, 14'b0_000_000_01_11_0_0_1); // -> REQ
        addv(9'b0_0_0_010_111, 14'b1_000_010_01_11_0_0_1); // has drops: swap, DRAIN
        addv(9'b0_0_0_000_111, 14'b0_000_000_01_11_0_0_1); // DRAIN done
        addv(9'b0_0_0_000_111, 14'b0_000_000_01_11_0_0_0); // READY

        r3 = 1'b1; has3 = 1'b0; ack3 = 1'b0; fd3 = '0; id3 = 3'b111;
        rst2 = 1'b1; force_busy = '0;
        fill_lat = 3; shift_lat = 5; ack_delay = 0; angles_total = 0;
        repeat (3) @(negedge clk);

        // 2-slot reset state
        rst2 = 1'b0;
        r3   = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy2}, 64'd0);
        check("rst_ptr", {63'd0, ptr2}, 64'd0);
        check("rst_itr", {62'd0, line2}, 64'd0);
        check("rst_pulses", {56'd0, st2, sw2, as2, per2, nr2, kick2}, 64'd0);
        check("rst_stall", {32'd0, stall2}, 64'd0);
        @(negedge clk);

        // Table-driven 3-slot vectors
        foreach (vq[i]) begin
            {r3, has3, ack3, fd3, id3} = vq[i].in;
            #1;
            got3 = {nr3, st3, sw3, ptr3, line3, as3, per3, busy3, kick3};
            exp3 = {vq[i].ex, |vq[i].ex[9:7]};
            total++;
            if (got3 !== exp3) begin
                bad++;
                $display("FAIL vec%0d got=%b exp=%b", i, got3, exp3);
            end
            @(negedge clk);
        end

        // One angle, fill 3 / shift 5
        fill_lat = 3; shift_lat = 5; ack_delay = 0; angles_total = 1;
        reset2();
        wait_idle("t1");
        check("t1_nstart", n_start, 4);
        check("t1_seq", {60'd0, seq4()}, 64'b0101);
        check("t1_nswap", n_swap, 4);
        check("t1_maxitr", {62'd0, max_itr}, 64'd3);
        check("t1_req", n_req_rise, 1);
        check("t1_per", n_per, 1);
        check("t1_as", n_as, 1);
        check("t1_onehot", n_multi, 0);

        // Two angles, ack delayed 5 cycles
        fill_lat = 2; shift_lat = 2; ack_delay = 5; angles_total = 2;
        reset2();
        wait_idle("t3");
        check("t3_nswap", n_swap, 8);
        check("t3_nstart", n_start, 8);
        check("t3_as", n_as, 2);
        check("t3_swap_in_req", n_swap_in_req, 0);
        check("t3_itr_after_as", {62'd0, itr_after_as}, 64'd0);
        check("t3_req", n_req_rise, 2);
        check("t3_onehot", n_multi, 0);

        // Next slot held busy 10 cycles while slot 0 reports done
        fill_lat = 6; shift_lat = 1; ack_delay = 0; angles_total = 1;
        force_busy = 2'b10;
        reset2();
        k = 0;
        while (!fd2[0] && k < 100) begin @(negedge clk); k++; end
        check("t4_filldone", {63'd0, fd2[0]}, 64'd1);
        for (int c = 0; c < 10; c++) begin
            check("t4_noswap", {62'd0, sw2}, 64'd0);
            @(negedge clk);
        end
        force_busy = 2'b00;
        #1;
        check("t4_swap_on_idle", {62'd0, sw2}, 64'd1);
        wait_idle("t4");
        check("t4_stall", {32'd0, stall2}, StallExp);
        check("t4_nswap", n_swap, 4);

        // Reset mid-run at line_itr=2
        fill_lat = 2; shift_lat = 2; ack_delay = 0; angles_total = 1;
        reset2();
        k = 0;
        while (line2 != 2'd2 && k < 200) begin @(negedge clk); k++; end
        check("t5_reach2", {62'd0, line2}, 64'd2);
        rst2 = 1'b1;
        angles_total = 0;
        #1;
        check("t5_rst_pulses", {58'd0, st2, sw2, as2, per2}, 64'd0);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        check("t5_after", {56'd0, busy2, ptr2, line2, st2, nr2, kick2}, 64'd0);
        check("t5_after_p", {60'd0, sw2, as2, per2}, 64'd0);
        angles_total = 1;
        wait_idle("t5");
        check("t5_nstart", n_start, 4);
        check("t5_seq", {60'd0, seq4()}, 64'b0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
